// File: rtl/alu8_synth_wrapper.sv
// alu8_synth_wrapper: 8-bit, 8-op ALU with one registered output stage.
// Ports: clk; rst_n (async, active-high); op[2:0]; a[7:0]; b[7:0]
//        -> result[7:0], alu_flag[3:0] {Z,N,C,V}, carry (= alu_flag[1]).
module alu8_synth_wrapper #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       alu_flag,
  output logic             carry
);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_NOT  = 3'b100;
  localparam logic [2:0] OP_SLL  = 3'b101;
  localparam logic [2:0] OP_SRL  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  logic [WIDTH:0]   sum9;
  logic [WIDTH:0]   dif9;
  logic [WIDTH:0]   shl9;
  logic [WIDTH:0]   shr9;
  logic [2:0]       sh;
  logic [WIDTH-1:0] r;
  logic             c;
  logic             v;

  assign sh   = b[2:0];
  assign sum9 = {1'b0, a} + {1'b0, b};
  // Top bit of the 9-bit difference is the borrow.
  assign dif9 = {1'b0, a} - {1'b0, b};
  // The extra bit catches the last bit shifted out;
  // it stays 0 for a zero shift amount.
  assign shl9 = {1'b0, a} << sh;
  assign shr9 = {a, 1'b0} >> sh;

  always_comb begin
    r = '0;
    c = 1'b0;
    v = 1'b0;
    unique case (op)
      OP_ADD: begin
        r = sum9[WIDTH-1:0];
        c = sum9[WIDTH];
        v = (a[WIDTH-1] == b[WIDTH-1]) &&
            (r[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        r = dif9[WIDTH-1:0];
        c = dif9[WIDTH];
        v = (a[WIDTH-1] != b[WIDTH-1]) &&
            (r[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_NOT:  r = ~a;
      OP_SLL: begin
        r = shl9[WIDTH-1:0];
        c = shl9[WIDTH];
      end
      OP_SRL: begin
        r = shr9[WIDTH:1];
        c = shr9[0];
      end
      OP_PASS: r = a;
      default: r = a;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      result   <= '0;
      alu_flag <= '0;
      carry    <= 1'b0;
    end else begin
      result   <= r;
      alu_flag <= {(r == '0), r[WIDTH-1], c, v};
      carry    <= c;
    end
  end

endmodule

// File: tb/tb_alu8_synth_wrapper.sv
// tb_alu8_synth_wrapper: directed + random checks of alu8_synth_wrapper.
// Compares result, flags and carry one edge after each input vector.
module tb_alu8_synth_wrapper;

  logic       clk;
  logic       rst_n;
  logic [2:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] result;
  logic [3:0] alu_flag;
  logic       carry;

  int n_checks = 0;
  int n_errors = 0;

  alu8_synth_wrapper dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .op       (op),
    .a        (a),
    .b        (b),
    .result   (result),
    .alu_flag (alu_flag),
    .carry    (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic vec(input string tag,
                     input logic [2:0] vop,
                     input logic [7:0] va,
                     input logic [7:0] vb,
                     input logic [7:0] er,
                     input logic [3:0] ef);
    op = vop;
    a  = va;
    b  = vb;
    @(posedge clk);
    #1;
    chk({tag, ".res"},   16'(result),   16'(er));
    chk({tag, ".flag"},  16'(alu_flag), 16'(ef));
    chk({tag, ".carry"}, 16'(carry),    16'(ef[1]));
  endtask

  // Independent reference: integer arithmetic and
  // bit-at-a-time shifting.
  function automatic logic [12:0] ref_alu(input logic [2:0] mop,
                                          input logic [7:0] ma,
                                          input logic [7:0] mb);
    int ai, bi, s, sa;
    logic [7:0] r;
    logic c, v;
    ai = int'(ma);
    bi = int'(mb);
    r = 8'h00;
    c = 1'b0;
    v = 1'b0;
    case (mop)
      3'd0: begin
        s = ai + bi;
        r = 8'(s % 256);
        c = (s > 255);
        sa = int'($signed(ma)) + int'($signed(mb));
        v = (sa > 127) || (sa < -128);
      end
      3'd1: begin
        s = ai - bi + 256;
        r = 8'(s % 256);
        c = (ai < bi);
        sa = int'($signed(ma)) - int'($signed(mb));
        v = (sa > 127) || (sa < -128);
      end
      3'd2: r = ma & mb;
      3'd3: r = ma | mb;
      3'd4: r = ~ma;
      3'd5: begin
        r = ma;
        for (int k = 0; k < int'(mb[2:0]); k++) begin
          c = r[7];
          r = {r[6:0], 1'b0};
        end
      end
      3'd6: begin
        r = ma;
        for (int k = 0; k < int'(mb[2:0]); k++) begin
          c = r[0];
          r = {1'b0, r[7:1]};
        end
      end
      default: r = ma;
    endcase
    return {r, (r == 8'h00), r[7], c, v};
  endfunction

  initial begin
    logic [12:0] m;
    rst_n = 1'b0;
    op = 3'b000;
    a  = 8'h05;
    b  = 8'h03;
    #2 rst_n = 1'b1;
    #1;
    chk("rst.res",   16'(result),   16'h0);
    chk("rst.flag",  16'(alu_flag), 16'h0);
    chk("rst.carry", 16'(carry),    16'h0);
    @(posedge clk);
    #1;
    chk("rst.hold",  16'(result),   16'h0);
    #3 rst_n = 1'b0;

    vec("add58",   3'b000, 8'h05, 8'h03, 8'h08, 4'b0000);

    // Mid-cycle async reset, no edge in between.
    #3 rst_n = 1'b1;
    #1;
    chk("arst.res",   16'(result),   16'h0);
    chk("arst.flag",  16'(alu_flag), 16'h0);
    chk("arst.carry", 16'(carry),    16'h0);
    @(posedge clk);
    #1;
    chk("arst.hold", 16'(result), 16'h0);
    #3 rst_n = 1'b0;
    vec("postrst", 3'b000, 8'h05, 8'h03, 8'h08, 4'b0000);

    vec("addwrap", 3'b000, 8'hFF, 8'h01, 8'h00, 4'b1010);
    vec("addovf",  3'b000, 8'h7F, 8'h01, 8'h80, 4'b0101);
    vec("add8080", 3'b000, 8'h80, 8'h80, 8'h00, 4'b1011);
    vec("subwrap", 3'b001, 8'h00, 8'h01, 8'hFF, 4'b0110);
    vec("subovf",  3'b001, 8'h80, 8'h01, 8'h7F, 4'b0001);
    vec("subzero", 3'b001, 8'h05, 8'h05, 8'h00, 4'b1000);
    vec("and",     3'b010, 8'hC3, 8'h0F, 8'h03, 4'b0000);
    vec("or",      3'b011, 8'hC3, 8'h0F, 8'hCF, 4'b0100);
    vec("not",     3'b100, 8'hC3, 8'h0F, 8'h3C, 4'b0000);
    vec("pass",    3'b111, 8'hC3, 8'h0F, 8'hC3, 4'b0100);
    vec("sll1",    3'b101, 8'h81, 8'hF9, 8'h02, 4'b0010);
    vec("srl1",    3'b110, 8'h81, 8'hF9, 8'h40, 4'b0010);
    vec("sll0",    3'b101, 8'h81, 8'h08, 8'h81, 4'b0100);
    vec("srl0",    3'b110, 8'h81, 8'h08, 8'h81, 4'b0100);
    vec("sll7",    3'b101, 8'h81, 8'h07, 8'h80, 4'b0100);
    vec("srl7",    3'b110, 8'h81, 8'h07, 8'h01, 4'b0000);
    vec("sll3",    3'b101, 8'h3C, 8'h03, 8'hE0, 4'b0110);
    vec("srl3",    3'b110, 8'h3C, 8'h03, 8'h07, 4'b0010);

    for (int i = 0; i < 100; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = 8'($urandom);
      b  = 8'($urandom);
      m  = ref_alu(op, a, b);
      @(posedge clk);
      #1;
      chk("rnd.res",   16'(result),   16'(m[11:4]));
      chk("rnd.flag",  16'(alu_flag), 16'(m[3:0]));
      chk("rnd.carry", 16'(carry),    16'(m[1]));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
